// File: rtl/tx_sched_pkg.sv
// Shared types for the TX response scheduler: FSM states, response sources
// and the default busy-acknowledge timeout.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;
  localparam int DEFAULT_TIMEOUT_WIDTH  = 10;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-way round-robin grant between the register-file and ALU hold slots.
// Grants only while enabled; a tie goes to the source not granted last.
module tx_rr_arbiter
  import tx_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic req_reg,
  input  logic req_alu,
  output logic gnt_reg,
  output logic gnt_alu
);

  src_t last_grant;

  always_comb begin
    gnt_reg = 1'b0;
    gnt_alu = 1'b0;
    if (en) begin
      if (req_reg && req_alu) begin
        if (last_grant == SRC_ALU) gnt_reg = 1'b1;
        else                       gnt_alu = 1'b1;
      end else begin
        gnt_reg = req_reg;
        gnt_alu = req_alu;
      end
    end
  end

  // Starting at ALU makes the register file win the first tie after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant <= SRC_ALU;
    end else if (gnt_reg) begin
      last_grant <= SRC_REG;
    end else if (gnt_alu) begin
      last_grant <= SRC_ALU;
    end
  end

endmodule

// File: rtl/tx_resp_scheduler.sv
// Schedules register-file and ALU response bytes onto the UART TX byte channel.
// Handshake: TX_DATA_VALID is a level held until TX_Busy is seen high, then the next byte waits for TX_Busy low.
module tx_resp_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  input  logic                     TX_Busy,
  input  logic                     Clr_Err,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_DATA_VALID,
  output logic                     Overflow,
  output logic                     Timeout_Err,
  output logic                     Sched_Busy,
  output logic [1:0]               fsm_state
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic                     reg_full;
  logic                     alu_full;
  logic [DATA_WIDTH-1:0]    reg_data;
  logic [ALU_OUT_WIDTH-1:0] alu_data;
  logic [DATA_WIDTH-1:0]    msb_byte;
  logic                     msb_pending;
  logic                     gnt_reg;
  logic                     gnt_alu;
  logic                     reg_take;
  logic                     alu_take;
  logic                     reg_drop;
  logic                     alu_drop;

  tx_rr_arbiter u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .en      (state == IDLE),
    .req_reg (reg_full),
    .req_alu (alu_full),
    .gnt_reg (gnt_reg),
    .gnt_alu (gnt_alu)
  );

  // A slot being granted on this edge is free for a strobe on the same edge.
  assign reg_take = RdData_Valid  && (!reg_full || gnt_reg);
  assign alu_take = ALU_OUT_VALID && (!alu_full || gnt_alu);
  assign reg_drop = RdData_Valid  && reg_full && !gnt_reg;
  assign alu_drop = ALU_OUT_VALID && alu_full && !gnt_alu;

  assign Sched_Busy = reg_full || alu_full || (state != IDLE);
  assign fsm_state  = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      reg_full <= 1'b0;
      alu_full <= 1'b0;
      reg_data <= '0;
      alu_data <= '0;
      Overflow <= 1'b0;
    end else begin
      if (reg_take) begin
        reg_full <= 1'b1;
        reg_data <= RdData;
      end else if (gnt_reg) begin
        reg_full <= 1'b0;
      end
      if (alu_take) begin
        alu_full <= 1'b1;
        alu_data <= ALU_OUT;
      end else if (gnt_alu) begin
        alu_full <= 1'b0;
      end
      Overflow <= reg_drop || alu_drop || (Overflow && !Clr_Err);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      msb_byte      <= '0;
      msb_pending   <= 1'b0;
      Timeout_Err   <= 1'b0;
    end else begin
      // A timeout on the same edge overrides the clear below.
      Timeout_Err <= Timeout_Err && !Clr_Err;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_reg) begin
            TX_P_DATA     <= reg_data;
            TX_DATA_VALID <= 1'b1;
            state         <= REQ;
          end else if (gnt_alu) begin
            TX_P_DATA     <= alu_data[DATA_WIDTH-1:0];
            msb_byte      <= alu_data[ALU_OUT_WIDTH-1:DATA_WIDTH];
            msb_pending   <= 1'b1;
            TX_DATA_VALID <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (TX_Busy) begin
            TX_DATA_VALID <= 1'b0;
            cnt           <= '0;
            state         <= WAIT_LOW;
          end else if (cnt == CNT_LAST) begin
            // Abandon the whole frame, including an ALU MSB not yet sent.
            TX_DATA_VALID <= 1'b0;
            Timeout_Err   <= 1'b1;
            msb_pending   <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!TX_Busy) begin
            if (msb_pending) begin
              TX_P_DATA     <= msb_byte;
              msb_pending   <= 1'b0;
              TX_DATA_VALID <= 1'b1;
              state         <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          TX_DATA_VALID <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Bench for tx_resp_scheduler: transaction-level model predicts byte order and
// sticky flags; a negedge monitor compares every offered byte against exp_q.
module tb_tx_resp_scheduler;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TC = 1000;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RdData = '0;
  logic          RdData_Valid = 1'b0;
  logic [AW-1:0] ALU_OUT = '0;
  logic          ALU_OUT_VALID = 1'b0;
  logic          TX_Busy = 1'b0;
  logic          Clr_Err = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_DATA_VALID;
  logic          Overflow;
  logic          Timeout_Err;
  logic          Sched_Busy;
  logic [1:0]    fsm_state;

  tx_resp_scheduler #(
    .DATA_WIDTH     (DW),
    .ALU_OUT_WIDTH  (AW),
    .TIMEOUT_WIDTH  (10),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RdData        (RdData),
    .RdData_Valid  (RdData_Valid),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VALID (ALU_OUT_VALID),
    .TX_Busy       (TX_Busy),
    .Clr_Err       (Clr_Err),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .Overflow      (Overflow),
    .Timeout_Err   (Timeout_Err),
    .Sched_Busy    (Sched_Busy),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  bit resp_en   = 1'b1;
  bit last_alu  = 1'b1;   // model: source granted last (reset value: ALU)

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  always @(negedge CLK) begin
    if (TX_DATA_VALID && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", TX_P_DATA);
      end else begin
        check("tx_byte", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
      end
    end
    if (prev_valid && prev_busy && RST) check("valid_drop", 32'(TX_DATA_VALID), 32'd0);
    prev_valid = TX_DATA_VALID;
    prev_busy  = TX_Busy;
  end

  // ---------------- UART TX responder ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (resp_en && RST && TX_DATA_VALID && !TX_Busy) begin
        repeat ($urandom_range(0, 4)) @(negedge CLK);
        TX_Busy = 1'b1;
        repeat ($urandom_range(1, 20)) @(negedge CLK);
        TX_Busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input bit rv, input logic [DW-1:0] rd, input bit av,
                       input logic [AW-1:0] ad, input bit clr);
    RdData        = rd;
    RdData_Valid  = rv;
    ALU_OUT       = ad;
    ALU_OUT_VALID = av;
    Clr_Err       = clr;
    @(posedge CLK);
    #1;
    RdData_Valid  = 1'b0;
    ALU_OUT_VALID = 1'b0;
    Clr_Err       = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (Sched_Busy && t < 3000) begin
      idle_cycles(1);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    idle_cycles(2);
  endtask

  // kind: 0 reg, 1 alu, 2 tie, 3 alu + two reg strobes (second dropped),
  //       4 reg then alu during reg byte, 5 back-to-back reg on the grant edge
  task automatic run_round(input int kind, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input logic [AW-1:0] a);
    bit exp_ovf = 1'b0;
    case (kind)
      0: begin
        exp_q.push_back(r0); last_alu = 1'b0;
        drive(1, r0, 0, '0, 0);
      end
      1: begin
        exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]); last_alu = 1'b1;
        drive(0, '0, 1, a, 0);
      end
      2: begin
        if (last_alu) begin
          exp_q.push_back(r0); exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
          last_alu = 1'b1;
        end else begin
          exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]); exp_q.push_back(r0);
          last_alu = 1'b0;
        end
        drive(1, r0, 1, a, 0);
      end
      3: begin
        exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]); exp_q.push_back(r0);
        last_alu = 1'b0; exp_ovf = 1'b1;
        drive(0, '0, 1, a, 0);
        idle_cycles(1);
        drive(1, r0, 0, '0, 0);
        drive(1, r1, 0, '0, 1);   // clear on the same edge as the drop: error must win
      end
      4: begin
        exp_q.push_back(r0); exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
        last_alu = 1'b1;
        drive(1, r0, 0, '0, 0);
        idle_cycles(1);
        drive(0, '0, 1, a, 0);
      end
      default: begin
        exp_q.push_back(r0); exp_q.push_back(r1); last_alu = 1'b0;
        drive(1, r0, 0, '0, 0);
        drive(1, r1, 0, '0, 0);
      end
    endcase
    wait_drain();
    check("drain_q", 32'(exp_q.size()), 32'd0);
    check("overflow", 32'(Overflow), 32'(exp_ovf));
    check("timeout_quiet", 32'(Timeout_Err), 32'd0);
    if (exp_ovf) begin
      drive(0, '0, 0, '0, 1);
      check("overflow_clr", 32'(Overflow), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hi;
    int t;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_data",  32'(TX_P_DATA), 32'd0);
    check("rst_valid", 32'(TX_DATA_VALID), 32'd0);
    check("rst_ovf",   32'(Overflow), 32'd0);
    check("rst_tmo",   32'(Timeout_Err), 32'd0);
    check("rst_busy",  32'(Sched_Busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    idle_cycles(2);

    run_round(0, 8'hA5, 8'h00, 16'h0000);
    run_round(1, 8'h00, 8'h00, 16'h1234);
    run_round(2, 8'h11, 8'h00, 16'hBEEF);
    run_round(2, 8'h11, 8'h00, 16'hBEEF);
    run_round(3, 8'h22, 8'h33, 16'hBEEF);
    run_round(5, 8'h3C, 8'hC3, 16'h0000);
    run_round(4, 8'h5A, 8'h00, 16'h9876);
    repeat (30) run_round(int'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 16'($urandom));

    // Busy never acknowledges: LSB offered for the full timeout, MSB abandoned.
    resp_en = 1'b0;
    exp_q.push_back(8'h66);
    last_alu = 1'b1;
    drive(0, '0, 1, 16'h5566, 0);
    t = 0;
    while (!TX_DATA_VALID && t < 10) begin idle_cycles(1); t++; end
    hi = 0;
    while (TX_DATA_VALID && hi < 1100) begin idle_cycles(1); hi++; end
    check("timeout_len", 32'(hi), 32'(TC));
    check("timeout_flag", 32'(Timeout_Err), 32'd1);
    check("timeout_state", 32'(fsm_state), 32'd0);
    check("timeout_busy", 32'(Sched_Busy), 32'd0);
    idle_cycles(20);
    check("timeout_q", 32'(exp_q.size()), 32'd0);
    drive(0, '0, 0, '0, 1);
    check("timeout_clr", 32'(Timeout_Err), 32'd0);

    // Reset while a byte is being requested.
    exp_q.push_back(8'h77);
    drive(1, 8'h77, 0, '0, 0);
    idle_cycles(3);
    check("req_valid", 32'(TX_DATA_VALID), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_mid_valid", 32'(TX_DATA_VALID), 32'd0);
    check("rst_mid_busy",  32'(Sched_Busy), 32'd0);
    check("rst_mid_data",  32'(TX_P_DATA), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    last_alu = 1'b1;
    resp_en  = 1'b1;
    idle_cycles(50);
    check("post_rst_valid", 32'(TX_DATA_VALID), 32'd0);
    check("post_rst_q", 32'(exp_q.size()), 32'd0);
    run_round(2, 8'h44, 8'h00, 16'hCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
